// File: rtl/axis_result_sink_pkg.sv
// Shared definitions for the result-sink endpoint of the 2x2 adder mesh demo.
// Holds the default AXIS widths, the mesh node addresses, the sink FSM state
// type and a saturating packet-counter helper.
package axis_result_sink_pkg;

    localparam int TDATAW = 32;
    localparam int TDESTW = 4;

    // Node addresses as carried in TDEST
    localparam logic [3:0] NODE_00 = 4'd0;
    localparam logic [3:0] NODE_01 = 4'd1;
    localparam logic [3:0] NODE_10 = 4'd2;
    localparam logic [3:0] NODE_11 = 4'd3;

    // Prefixed literals keep clear of the DONE output port on the top level
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_REP0,
        ST_REP1,
        ST_DONE
    } sink_state_t;

    // Packet counter increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axis_result_sink_bp_gen.sv
// Rotating back-pressure pattern generator, reusable on any AXIS endpoint.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset (loads PAT)
//   load  in  reload PAT (takes priority over en)
//   en    in  rotate the pattern left by one bit
//   ready out bit 0 of the pattern register
module axis_bp_gen #(
    parameter logic [7:0] PAT = 8'hFF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic ready
);

    logic [7:0] pat;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            pat <= PAT;
        end else if (en) begin
            pat <= {pat[6:0], pat[7]};
        end
    end

    assign ready = pat[0];

endmodule

// File: rtl/axis_result_sink.sv
// AXI-Stream result sink at mesh node [1][1]. Consumes result packets with
// programmable back-pressure, accumulates a flit sum, packet count, last
// result and a sticky TDEST-mismatch flag, then returns a 2-flit report
// packet {PKT_COUNT, SUM} to REPORT_DEST.
// Ports:
//   CLK, RST (sync, active-high), START (1-cycle pulse)
//   AXIS_S_*   slave stream from the NoC (TVALID/TREADY/TDATA/TLAST/TDEST)
//   AXIS_M_*   master stream into the NoC, all outputs registered
//   PKT_COUNT  packets completed, SUM  wrapping sum of accepted TDATA
//   LAST_RESULT TDATA of last accepted TLAST flit, DEST_ERR sticky flag
//   DONE       high while the FSM rests in its done state
module axis_result_sink
    import axis_result_sink_pkg::*;
#(
    parameter int                TDATAW      = axis_result_sink_pkg::TDATAW,
    parameter int                TDESTW      = axis_result_sink_pkg::TDESTW,
    parameter int                NUM_PACKETS = 8,
    parameter logic [TDESTW-1:0] MY_ADDR     = TDESTW'(axis_result_sink_pkg::NODE_11),
    parameter logic [TDESTW-1:0] REPORT_DEST = TDESTW'(axis_result_sink_pkg::NODE_00),
    parameter logic [7:0]        READY_PAT   = 8'hFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic [15:0]       PKT_COUNT,
    output logic [TDATAW-1:0] SUM,
    output logic [TDATAW-1:0] LAST_RESULT,
    output logic              DEST_ERR,
    output logic              DONE
);

    sink_state_t state;
    logic        start_ok;
    logic        accept;
    logic        pat_ready;
    logic [15:0] cnt_next;

    // START only matters while idle or done
    assign start_ok = START && (state == ST_IDLE || state == ST_DONE);
    assign accept   = AXIS_S_TVALID && AXIS_S_TREADY;
    assign cnt_next = sat_inc16(PKT_COUNT);

    axis_bp_gen #(
        .PAT (READY_PAT)
    ) u_bp_gen (
        .clk   (CLK),
        .rst   (RST),
        .load  (start_ok),
        .en    (state == ST_COLLECT),
        .ready (pat_ready)
    );

    assign AXIS_S_TREADY = (state == ST_COLLECT) && pat_ready;
    assign DONE          = (state == ST_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            PKT_COUNT     <= '0;
            SUM           <= '0;
            LAST_RESULT   <= '0;
            DEST_ERR      <= 1'b0;
            AXIS_M_TVALID <= 1'b0;
            AXIS_M_TDATA  <= '0;
            AXIS_M_TLAST  <= 1'b0;
            AXIS_M_TDEST  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state       <= ST_COLLECT;
                        PKT_COUNT   <= '0;
                        SUM         <= '0;
                        LAST_RESULT <= '0;
                        DEST_ERR    <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        SUM <= SUM + AXIS_S_TDATA;
                        if (AXIS_S_TDEST != MY_ADDR) begin
                            DEST_ERR <= 1'b1;
                        end
                        if (AXIS_S_TLAST) begin
                            PKT_COUNT   <= cnt_next;
                            LAST_RESULT <= AXIS_S_TDATA;
                            // Leaving COLLECT here drops TREADY before any further flit
                            if (cnt_next == 16'(NUM_PACKETS)) begin
                                state <= ST_REP0;
                            end
                        end
                    end
                end
                ST_REP0: begin
                    // First REP0 cycle loads the registered report head;
                    // the state only advances on a handshake after that.
                    if (!AXIS_M_TVALID) begin
                        AXIS_M_TVALID <= 1'b1;
                        AXIS_M_TDATA  <= TDATAW'(PKT_COUNT);
                        AXIS_M_TLAST  <= 1'b0;
                        AXIS_M_TDEST  <= REPORT_DEST;
                    end else if (AXIS_M_TREADY) begin
                        state        <= ST_REP1;
                        AXIS_M_TDATA <= SUM;
                        AXIS_M_TLAST <= 1'b1;
                    end
                end
                ST_REP1: begin
                    if (AXIS_M_TREADY) begin
                        state         <= ST_DONE;
                        AXIS_M_TVALID <= 1'b0;
                        AXIS_M_TLAST  <= 1'b0;
                        AXIS_M_TDATA  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_result_sink.sv
module tb_axis_result_sink;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tdest;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tdest;
    logic [15:0] pkt_count;
    logic [31:0] sum, last_result;
    logic        dest_err, done;

    // Second instance for the alternating back-pressure pattern
    logic        b_start, b_tvalid, b_tready, b_tlast, b_m_tready;
    logic [31:0] b_tdata;
    logic [3:0]  b_tdest;
    logic        b_m_tvalid, b_m_tlast;
    logic [31:0] b_m_tdata;
    logic [3:0]  b_m_tdest;
    logic [15:0] b_pkt_count;
    logic [31:0] b_sum, b_last_result;
    logic        b_dest_err, b_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_result_sink #(
        .TDATAW(32), .TDESTW(4), .NUM_PACKETS(2),
        .MY_ADDR(4'd3), .REPORT_DEST(4'd0), .READY_PAT(8'hFF)
    ) dut (
        .CLK(clk), .RST(rst), .START(start),
        .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(s_tready), .AXIS_S_TDATA(s_tdata),
        .AXIS_S_TLAST(s_tlast), .AXIS_S_TDEST(s_tdest),
        .AXIS_M_TVALID(m_tvalid), .AXIS_M_TREADY(m_tready), .AXIS_M_TDATA(m_tdata),
        .AXIS_M_TLAST(m_tlast), .AXIS_M_TDEST(m_tdest),
        .PKT_COUNT(pkt_count), .SUM(sum), .LAST_RESULT(last_result),
        .DEST_ERR(dest_err), .DONE(done)
    );

    axis_result_sink #(
        .TDATAW(32), .TDESTW(4), .NUM_PACKETS(4),
        .MY_ADDR(4'd3), .REPORT_DEST(4'd0), .READY_PAT(8'b01010101)
    ) dut_bp (
        .CLK(clk), .RST(rst), .START(b_start),
        .AXIS_S_TVALID(b_tvalid), .AXIS_S_TREADY(b_tready), .AXIS_S_TDATA(b_tdata),
        .AXIS_S_TLAST(b_tlast), .AXIS_S_TDEST(b_tdest),
        .AXIS_M_TVALID(b_m_tvalid), .AXIS_M_TREADY(b_m_tready), .AXIS_M_TDATA(b_m_tdata),
        .AXIS_M_TLAST(b_m_tlast), .AXIS_M_TDEST(b_m_tdest),
        .PKT_COUNT(b_pkt_count), .SUM(b_sum), .LAST_RESULT(b_last_result),
        .DEST_ERR(b_dest_err), .DONE(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one flit and hold it until the accept edge has passed
    task automatic send(input logic [31:0] d, input logic l, input logic [3:0] de);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_tdest  = de;
        while (!s_tready && n < 20) begin
            tick();
            n++;
        end
        check("s_tready_wait", {31'b0, s_tready}, 32'd1);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_mvalid();
        int n = 0;
        while (!m_tvalid && n < 20) begin
            tick();
            n++;
        end
        check("m_tvalid_wait", {31'b0, m_tvalid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tdest = 4'd3;
        m_tready = 1'b1;
        b_start = 1'b0; b_tvalid = 1'b0; b_tdata = 32'd3; b_tlast = 1'b0;
        b_tdest = 4'd3; b_m_tready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_pkt_count", {16'b0, pkt_count}, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_last_result", last_result, 32'd0);
        check("rst_dest_err", {31'b0, dest_err}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_s_tready", {31'b0, s_tready}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic collection and report
        pulse_start();
        check("t1_s_tready", {31'b0, s_tready}, 32'd1);
        send(32'd5, 1'b0, 4'd3);
        check("t1_sum_a", sum, 32'd5);
        send(32'd7, 1'b1, 4'd3);
        check("t1_pkt_a", {16'b0, pkt_count}, 32'd1);
        check("t1_last_a", last_result, 32'd7);
        check("t1_sum_b", sum, 32'd12);
        send(32'd3, 1'b1, 4'd3);
        check("t1_pkt_b", {16'b0, pkt_count}, 32'd2);
        check("t1_sum_c", sum, 32'd15);
        check("t1_last_b", last_result, 32'd3);
        check("t1_s_tready_off", {31'b0, s_tready}, 32'd0);
        wait_mvalid();
        check("t1_rep0_data", m_tdata, 32'd2);
        check("t1_rep0_last", {31'b0, m_tlast}, 32'd0);
        check("t1_rep0_dest", {28'b0, m_tdest}, 32'd0);
        tick();
        check("t1_rep1_valid", {31'b0, m_tvalid}, 32'd1);
        check("t1_rep1_data", m_tdata, 32'd15);
        check("t1_rep1_last", {31'b0, m_tlast}, 32'd1);
        check("t1_rep1_dest", {28'b0, m_tdest}, 32'd0);
        tick();
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_m_tvalid_off", {31'b0, m_tvalid}, 32'd0);

        // Alternating back-pressure, TVALID held high
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_tready", {31'b0, b_tready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        b_tvalid = 1'b0;
        check("t2_sum", b_sum, 32'd12);
        check("t2_pkt", {16'b0, b_pkt_count}, 32'd0);

        // Report stalled by M_TREADY low
        m_tready = 1'b0;
        pulse_start();
        check("t3_clr_pkt", {16'b0, pkt_count}, 32'd0);
        check("t3_clr_sum", sum, 32'd0);
        check("t3_done_off", {31'b0, done}, 32'd0);
        send(32'd10, 1'b1, 4'd3);
        send(32'd20, 1'b1, 4'd3);
        wait_mvalid();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", {31'b0, m_tvalid}, 32'd1);
            check("t3_hold_data", m_tdata, 32'd2);
            check("t3_hold_last", {31'b0, m_tlast}, 32'd0);
            tick();
        end
        m_tready = 1'b1;
        tick();
        check("t3_rep1_data", m_tdata, 32'd30);
        check("t3_rep1_last", {31'b0, m_tlast}, 32'd1);
        tick();
        check("t3_done", {31'b0, done}, 32'd1);

        // TDEST mismatch
        pulse_start();
        send(32'd4, 1'b0, 4'd1);
        check("t4_dest_err", {31'b0, dest_err}, 32'd1);
        check("t4_sum_a", sum, 32'd4);
        send(32'd6, 1'b1, 4'd3);
        check("t4_dest_err_sticky", {31'b0, dest_err}, 32'd1);
        check("t4_pkt", {16'b0, pkt_count}, 32'd1);
        send(32'd1, 1'b1, 4'd3);
        wait_mvalid();
        check("t4_rep0_data", m_tdata, 32'd2);
        tick();
        check("t4_rep1_data", m_tdata, 32'd11);
        tick();
        check("t4_done", {31'b0, done}, 32'd1);
        check("t4_dest_err_done", {31'b0, dest_err}, 32'd1);
        pulse_start();
        check("t4_dest_err_clr", {31'b0, dest_err}, 32'd0);
        check("t4_sum_clr", sum, 32'd0);

        // Reset mid-packet, then mid-report
        send(32'd9, 1'b0, 4'd3);
        check("t5_sum_partial", sum, 32'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_sum", sum, 32'd0);
        check("t5_rst_pkt", {16'b0, pkt_count}, 32'd0);
        check("t5_rst_dest_err", {31'b0, dest_err}, 32'd0);
        check("t5_rst_s_tready", {31'b0, s_tready}, 32'd0);
        check("t5_rst_done", {31'b0, done}, 32'd0);
        pulse_start();
        send(32'd1, 1'b1, 4'd3);
        send(32'd2, 1'b1, 4'd3);
        check("t5_sum_clean", sum, 32'd3);
        check("t5_last_clean", last_result, 32'd2);
        wait_mvalid();
        tick();
        check("t5_in_rep1", {31'b0, m_tlast}, 32'd1);
        rst = 1'b1;
        m_tready = 1'b0;
        tick();
        rst = 1'b0;
        m_tready = 1'b1;
        check("t5_rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("t5_rst_m_tdata", m_tdata, 32'd0);
        check("t5_rst_sum2", sum, 32'd0);
        check("t5_rst_pkt2", {16'b0, pkt_count}, 32'd0);
        tick();
        tick();
        check("t5_abandoned", {31'b0, m_tvalid}, 32'd0);
        check("t5_idle_not_done", {31'b0, done}, 32'd0);

        // Sum wrap and ignored START in COLLECT
        pulse_start();
        send(32'hFFFF_FFFF, 1'b0, 4'd3);
        pulse_start();
        check("t6_start_ignored", sum, 32'hFFFF_FFFF);
        check("t6_still_collect", {31'b0, s_tready}, 32'd1);
        send(32'd2, 1'b1, 4'd3);
        check("t6_sum_wrap", sum, 32'd1);
        check("t6_pkt", {16'b0, pkt_count}, 32'd1);
        check("t6_last", last_result, 32'd2);
        send(32'd5, 1'b1, 4'd3);
        wait_mvalid();
        check("t6_rep0_data", m_tdata, 32'd2);
        tick();
        check("t6_rep1_data", m_tdata, 32'd6);
        tick();
        check("t6_done", {31'b0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
